// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the sequential floating-point multiplier:
// FSM states, exception codes, radix-4 Booth digit recoding and parameter defaults.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_NORM,
    ST_DONE
  } fp_state_t;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_UNF  = 2'b10;
  localparam logic [1:0] EXC_INV  = 2'b11;

  typedef enum logic [2:0] {
    BD_ZERO = 3'b000,
    BD_POS1 = 3'b001,
    BD_POS2 = 3'b010,
    BD_NEG1 = 3'b101,
    BD_NEG2 = 3'b110
  } booth_digit_t;

  // Window is {y[2i+1], y[2i], y[2i-1]}
  function automatic booth_digit_t booth_recode(input logic [2:0] window);
    case (window)
      3'b001, 3'b010: return BD_POS1;
      3'b011:         return BD_POS2;
      3'b100:         return BD_NEG2;
      3'b101, 3'b110: return BD_NEG1;
      default:        return BD_ZERO;
    endcase
  endfunction

  function automatic int unsigned booth_iter(input int unsigned man_w);
    return (man_w + 4) / 2;
  endfunction

  function automatic int unsigned default_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/booth_r4_step.sv
// One radix-4 Booth iteration: recode a 3-bit multiplier window and fold the
// selected multiple of the multiplicand into the running partial product.
module booth_r4_step
  import fp_mul_pkg::*;
#(
  parameter int unsigned MW = 11,
  parameter int unsigned AW = 24
) (
  input  logic [2:0]    window,
  input  logic [MW-1:0] mcand,
  input  logic [AW-1:0] acc,
  output logic [AW-1:0] acc_next
);

  booth_digit_t  digit;
  logic [AW-1:0] m_ext;
  logic [AW-1:0] m_dbl;
  logic [AW-1:0] addend;

  // Digits arrive most-significant first, so the running sum is scaled by 4
  // before each new multiple is added (Horner form of the Booth sum).
  always_comb begin
    digit  = booth_recode(window);
    m_ext  = AW'(mcand);
    m_dbl  = {m_ext[AW-2:0], 1'b0};
    addend = '0;
    unique case (digit)
      BD_POS1: addend = m_ext;
      BD_POS2: addend = m_dbl;
      BD_NEG1: addend = -m_ext;
      BD_NEG2: addend = -m_dbl;
      default: addend = '0;
    endcase
    acc_next = {acc[AW-3:0], 2'b00} + addend;
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-style FP multiplier with radix-4 Booth mantissa core and
// valid/ready handshakes. Define FP_MUL_RNE_EN for round-to-nearest-even, else truncation.
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  parameter int unsigned BIAS  = default_bias(EXP_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] op,
  output logic [1:0]           exceptions
);

  localparam int unsigned ITER = booth_iter(MAN_W);
  localparam int unsigned MW   = MAN_W + 1;
  localparam int unsigned AW   = 2 * MW + 2;
  localparam int unsigned PW   = 2 * MW;
  localparam int unsigned MR   = 2 * ITER + 1;
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned CW   = $clog2(ITER);
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);

  fp_state_t state, state_nxt;

  logic                 accept;
  logic [EXP_W-1:0]     a_exp, b_exp;
  logic                 sign_q, inv_q, zero_q;
  logic signed [EW-1:0] esum_q;
  logic [MW-1:0]        mcand_q;
  logic [MR-1:0]        mplier_q;
  logic [AW-1:0]        acc_q, acc_nxt;
  logic [CW-1:0]        cnt_q;
  logic [EXP_W+MAN_W:0] op_q, op_d;
  logic [1:0]           exc_q, exc_d;

  logic                 hi;
  logic [MAN_W-1:0]     frac_t, frac_r;
  logic signed [EW-1:0] e_n, e_r;
`ifdef FP_MUL_RNE_EN
  logic                 guard, sticky, rnd_up;
  logic [MAN_W:0]       rnd;
`endif

  always_comb begin
    a_exp = a[MAN_W +: EXP_W];
    b_exp = b[MAN_W +: EXP_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_MUL;
      end
      ST_MUL:  if (cnt_q == CW'(ITER - 1)) state_nxt = ST_NORM;
      ST_NORM: state_nxt = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  booth_r4_step #(
    .MW(MW),
    .AW(AW)
  ) u_step (
    .window  (mplier_q[MR-1 -: 3]),
    .mcand   (mcand_q),
    .acc     (acc_q),
    .acc_next(acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      inv_q    <= 1'b0;
      zero_q   <= 1'b0;
      esum_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      exc_q    <= EXC_NONE;
    end else begin
      if (accept) begin
        sign_q   <= a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
        esum_q   <= EW'(a_exp) + EW'(b_exp);
        inv_q    <= (&a_exp) | (&b_exp);
        zero_q   <= (a_exp == '0) | (b_exp == '0);
        mcand_q  <= {1'b1, a[MAN_W-1:0]};
        mplier_q <= MR'({2'b00, 1'b1, b[MAN_W-1:0], 1'b0});
        acc_q    <= '0;
        cnt_q    <= '0;
      end
      if (state == ST_MUL) begin
        acc_q    <= acc_nxt;
        mplier_q <= mplier_q << 2;
        cnt_q    <= cnt_q + CW'(1);
      end
      if (state == ST_NORM) begin
        op_q  <= op_d;
        exc_q <= exc_d;
      end
    end
  end

  // Product sits in acc_q[PW-1:0] with 2*MAN_W fraction bits; value is in [1,4).
  always_comb begin
    hi     = acc_q[PW-1];
    e_n    = esum_q - EW'(BIAS) + EW'(hi);
    frac_t = hi ? acc_q[PW-2 -: MAN_W] : acc_q[PW-3 -: MAN_W];
`ifdef FP_MUL_RNE_EN
    guard  = hi ? acc_q[MAN_W] : acc_q[MAN_W-1];
    sticky = hi ? (|acc_q[MAN_W-1:0]) : (|acc_q[MAN_W-2:0]);
    rnd_up = guard & (sticky | frac_t[0]);
    rnd    = {1'b0, frac_t} + {{MAN_W{1'b0}}, rnd_up};
    frac_r = rnd[MAN_W-1:0];
    e_r    = e_n + EW'(rnd[MAN_W]);
`else
    frac_r = frac_t;
    e_r    = e_n;
`endif
    op_d  = '0;
    exc_d = EXC_NONE;
    if (inv_q) begin
      exc_d = EXC_INV;
      op_d  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (zero_q) begin
      op_d = {sign_q, {(EXP_W+MAN_W){1'b0}}};
    end else if (e_r >= E_MAX) begin
      exc_d = EXC_OVF;
      op_d  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (e_r[EW-1] || (e_r == '0)) begin
      exc_d = EXC_UNF;
      op_d  = {sign_q, {(EXP_W+MAN_W){1'b0}}};
    end else begin
      op_d = {sign_q, e_r[EXP_W-1:0], frac_r};
    end
  end

  assign op         = op_q;
  assign exceptions = exc_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq: directed and random operands checked against
// an integer-arithmetic model of the multiply, with latency, stall and reset checks.
module tb_fp_mul_seq;
  import fp_mul_pkg::*;

  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;
  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int          ITER  = (MAN_W + 4) / 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] op;
  logic [1:0]   exceptions;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [17:0] exp_q[$];
  int          acc_q[$];
  bit          bp_low  = 1'b0;
  bit          bp_rand = 1'b0;
  bit          hold    = 1'b0;
  logic [17:0] held;
  logic [17:0] mon_exp;
  int          mon_acc;

  fp_mul_seq #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op        (op),
    .exceptions(exceptions)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Returns {exceptions, op}: exact integer product, then normalise/round/classify.
  function automatic logic [17:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int ea, eb, e, p, q, sh;
    bit s;
    s  = x[15] ^ y[15];
    ea = int'(x[14:10]);
    eb = int'(y[14:10]);
    if (ea == 31 || eb == 31) return {2'b11, 16'h7E00};
    if (ea == 0 || eb == 0)   return {2'b00, s, 15'b0};
    p  = (1024 + int'(x[9:0])) * (1024 + int'(y[9:0]));
    e  = ea + eb - 15;
    sh = 10;
    if (p >= (1 << 21)) begin
      sh = 11;
      e  = e + 1;
    end
    q = p >> sh;
`ifdef FP_MUL_RNE_EN
    begin
      int r, half;
      r    = p - (q << sh);
      half = 1 << (sh - 1);
      if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
    end
`endif
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    if (e >= 31) return {2'b01, s, 5'h1F, 10'h000};
    if (e <= 0)  return {2'b10, s, 15'b0};
    return {2'b00, s, e[4:0], q[9:0]};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [4:0]  e;
    int unsigned k;
    k = $urandom_range(0, 15);
    if (k == 0)      e = 5'd0;
    else if (k == 1) e = 5'h1F;
    else if (k < 4)  e = 5'($urandom);
    else             e = 5'($urandom_range(6, 24));
    return {1'($urandom), e, 10'($urandom)};
  endfunction

  // Holds in_valid high with junk operands while busy; those must be ignored.
  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, output int acc_edge);
    int unsigned n;
    n        = 0;
    acc_edge = -1;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      a        = xa;
      b        = xb;
      acc_edge = cyc + 1;
      exp_q.push_back(model(xa, xb));
      acc_q.push_back(acc_edge);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (bp_low)       out_ready = 1'b0;
    else if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    else              out_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else if (out_valid) begin
      check("in_ready_low_while_valid", 32'(in_ready), 32'd0);
      if (hold) begin
        check("result_stable", 32'({exceptions, op}), 32'(held));
      end else if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_acc = acc_q.pop_front();
        check("op", 32'(op), 32'(mon_exp[15:0]));
        check("exceptions", 32'(exceptions), 32'(mon_exp[17:16]));
        check("latency", 32'(cyc + 1 - mon_acc), 32'(ITER + 2));
      end
      hold = !out_ready;
      held = {exceptions, op};
    end else begin
      hold = 1'b0;
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1;
    int unsigned n;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_op", 32'(op), 32'd0);
    check("reset_exceptions", 32'(exceptions), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(16'h4000, 16'h4200, t0);
    send(16'hBE00, 16'h4000, t0);
    bp_low = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_result_arrives", 32'(out_valid), 32'd1);
    repeat (5) @(negedge clk);
    bp_low = 1'b0;

    send(16'h3C01, 16'h3E00, t0);
    send(16'h7800, 16'h7800, t0);
    send(16'h0400, 16'h0400, t0);
    send(16'h0000, 16'h7C00, t0);

    send(16'h4000, 16'h4200, t0);
    send(16'h3C00, 16'h3C00, t1);
    check("throughput", 32'(t1 - t0), 32'(ITER + 3));

    bp_rand = 1'b1;
    repeat (150) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(rand_operand(), rand_operand(), t0);
    end
    bp_rand = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    send(16'h4000, 16'h4200, t0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_state_idle", 32'(dut.state == ST_IDLE), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_output_after_abort", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Parametrised, multi-cycle IEEE-style floating-point multiplier; next generation of the 16-bit combinational half-precision multiplier.
- Generic in exponent and mantissa width.
- Iterative radix-4 Booth mantissa core: one recoded digit per clock.
- Adds valid/ready handshakes, normalisation, rounding, deterministic exception results, and special-operand handling.
- Sits between operand registers and the ALU result bus.

Parameters:
- EXP_W, 5: exponent field width.
- MAN_W, 10: stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.
- BIAS, 2**(EXP_W-1)-1: exponent bias.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- a  in  W  operand A {sign, exp, frac}
- b  in  W  operand B
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- op  out  W  product
- exceptions  out  2  00 valid, 01 overflow, 10 underflow, 11 invalid

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE, in_ready=1, out_valid=0, op=0, exceptions=00.
- Reset asserted mid-operation aborts the operation; no partial result is ever emitted.
- FSM IDLE -> MUL -> NORM -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready captures a, b.
  - Captures sign=a.s^b.s.
  - Captures exp sum ea+eb as EXP_W+2 signed.
  - Loads Booth multiplicand {1,fracA} and multiplier {00,1,fracB,0}.
  - Goes to MUL.
- MUL:
  - ITER=(MAN_W+4)/2 cycles (7 at default).
  - Each cycle recodes 3 multiplier bits to a digit in {-2,-1,0,+1,+2}.
  - Accumulates into a 2*(MAN_W+1)+2 bit partial product, then shifts 2.
  - in_ready=0.
- NORM (one cycle):
  - Product P in [1,4).
  - If P>=2: shift right 1, e+=1.
  - e = ea+eb-BIAS (+1).
  - Round to MAN_W fraction bits per FP_MUL_RNE_EN.
  - Rounding carry-out renormalises (e+=1, frac=0).
  - Classify, in priority order:
    - Either exp all-ones (Inf/NaN), or zero×Inf: exceptions=11, op={0, all-ones exp, 1 followed by zeros}.
    - Either exp==0 (zero; subnormals flushed to zero): exceptions=00, op={sign,0}.
    - e>=2**EXP_W-1: exceptions=01, op={sign, all-ones, 0} (infinity).
    - e<=0: exceptions=10, op={sign,0}.
    - Otherwise exceptions=00, op={sign, e[EXP_W-1:0], frac}.
- DONE:
  - out_valid=1; op and exceptions are stable while out_ready=0.
  - out_valid&out_ready -> IDLE, out_valid=0 next cycle.
- Latency: accept edge to out_valid = ITER+2 cycles (9 at default).
- Throughput: one operation per ITER+3 cycles with out_ready tied high.
- in_ready is deasserted whenever state != IDLE. in_valid in other states is ignored, not queued.
- Special operands take the same latency as normal ones, so timing is uniform.

Optional Feature:
- Macro FP_MUL_RNE_EN.
- Defined: round-to-nearest-even using guard bit and OR-reduced sticky bit.
- Undefined: truncation; guard and sticky are discarded and there is no rounding carry.
- Exception classification is identical in both modes.

Decomposition:
- Package fp_mul_pkg:
  - FSM state enum.
  - Exception code constants EXC_NONE/EXC_OVF/EXC_UNF/EXC_INV.
  - Booth digit encoding.
  - Functions for the ITER and BIAS defaults.
- Sub-module booth_r4_step:
  - Combinational.
  - Takes a 3-bit window, the multiplicand and the accumulator.
  - Returns the next accumulator.
  - Instantiated once and reused each MUL cycle.

Test Plan:
- 0x4000 × 0x4200 (2.0×3.0) -> op=0x4600, exceptions=00, out_valid exactly 9 cycles after accept.
- 0xBE00 × 0x4000 (-1.5×2.0) -> op=0xC200, exceptions=00; then hold out_ready=0 for 5 cycles -> op stable and in_ready=0 throughout.
- 0x3C01 × 0x3E00 -> op=0x3E02 with FP_MUL_RNE_EN (tie rounds to even), 0x3E01 without.
- 0x7800 × 0x7800 -> exceptions=01, op=0x7C00.
- 0x0400 × 0x0400 -> exceptions=10, op=0x0000.
- 0x0000 × 0x7C00 -> exceptions=11, op=0x7E00.
- Separately: assert rst_n low during MUL -> out_valid stays 0, state IDLE, in_ready=1.
